// File: rtl/pipe_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipe_stall_ctrl_if : hazard requests in, stage enables/clears/status out
// Revision: 1.0
// ============================================================================
interface pipe_stall_ctrl_if;
    logic        load_use;
    logic        branch_taken;
    logic        mc_start;
    logic        mem_wait;
    logic        pc_en;
    logic [3:0]  en;
    logic [3:0]  clr;
    logic        busy;
    logic        mc_done;
    logic [15:0] stall_cnt;

    modport master (
        output load_use, branch_taken, mc_start, mem_wait,
        input  pc_en, en, clr, busy, mc_done, stall_cnt
    );

    modport slave (
        input  load_use, branch_taken, mc_start, mem_wait,
        output pc_en, en, clr, busy, mc_done, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_stall_ctrl : 5-stage pipeline stall/flush control with multi-cycle EX
// Revision: 1.0
// ============================================================================
module pipe_stall_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 3
) (
    input  wire logic        clock,
    input  wire logic        reset,
    pipe_stall_ctrl_if.slave bus
);
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(MC_LAT - 2);
    localparam logic [15:0]      C_SAT      = 16'hFFFF;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_stall_cnt;

    logic       w_pc_en;
    logic [3:0] w_en;
    logic [3:0] w_clr;
    logic       w_busy;
    logic       w_mc_done;

    always_comb begin
        w_pc_en   = 1'b0;
        w_en      = 4'b0000;
        w_clr     = 4'b0000;
        w_busy    = 1'b0;
        w_mc_done = 1'b0;
        if (!reset) begin
            w_clr = 4'b1111;
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.mem_wait) begin
                        w_pc_en = 1'b0;
                    end else if (bus.mc_start) begin
                        w_en   = 4'b1000;
                        w_clr  = 4'b1000;
                        w_busy = 1'b1;
                    end else if (bus.branch_taken) begin
                        w_pc_en = 1'b1;
                        w_en    = 4'b1111;
                        w_clr   = 4'b0011;
                    end else if (bus.load_use) begin
                        w_en  = 4'b1110;
                        w_clr = 4'b0010;
                    end else begin
                        w_pc_en = 1'b1;
                        w_en    = 4'b1111;
                    end
                end
                MC_WAIT: begin
                    w_busy = 1'b1;
                    if (r_cnt != '0 || bus.mem_wait) begin
                        // Memory wait freezes everything; otherwise only MEM/WB drains
                        if (!bus.mem_wait) begin
                            w_en  = 4'b1000;
                            w_clr = 4'b1000;
                        end
                    end else begin
                        w_mc_done = 1'b1;
                        w_pc_en   = 1'b1;
                        w_en      = 4'b1111;
                    end
                end
                default: begin
                    w_pc_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (!w_pc_en && r_stall_cnt != C_SAT) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            case (r_state)
                RUN: begin
                    if (!bus.mem_wait && bus.mc_start) begin
                        r_state <= MC_WAIT;
                        r_cnt   <= C_CNT_INIT;
                    end
                end
                MC_WAIT: begin
                    // Countdown runs through memory waits; only the release waits
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!bus.mem_wait) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign bus.pc_en     = w_pc_en;
    assign bus.en        = w_en;
    assign bus.clr       = w_clr;
    assign bus.busy      = w_busy;
    assign bus.mc_done   = w_mc_done;
    assign bus.stall_cnt = r_stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_stall_ctrl : directed vectors, scoreboard queue checked by a monitor
// Revision: 1.0
// ============================================================================
module tb_pipe_stall_ctrl;
    logic clock;
    logic reset;

    pipe_stall_ctrl_if bus ();

    pipe_stall_ctrl #(
        .MC_LAT (4),
        .CNT_W  (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string       nm;
        logic        pc;
        logic [3:0]  en;
        logic [3:0]  clr;
        logic        busy;
        logic        done;
        logic [15:0] st;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_stall;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if ({bus.pc_en, bus.en, bus.clr, bus.busy, bus.mc_done, bus.stall_cnt} !==
                {e.pc, e.en, e.clr, e.busy, e.done, e.st}) begin
                errors++;
                $display("FAIL %s: got pc_en=%b en=%b clr=%b busy=%b mc_done=%b stall_cnt=%h, expected pc_en=%b en=%b clr=%b busy=%b mc_done=%b stall_cnt=%h",
                         e.nm, bus.pc_en, bus.en, bus.clr, bus.busy, bus.mc_done, bus.stall_cnt,
                         e.pc, e.en, e.clr, e.busy, e.done, e.st);
            end
        end
    end

    // One clock cycle: apply inputs, queue the expected outputs for this cycle
    task automatic step(input string nm, input logic rstv, input logic lu, input logic bt,
                        input logic ms, input logic mw, input logic xpc, input logic [3:0] xen,
                        input logic [3:0] xclr, input logic xbusy, input logic xdone);
        exp_t x;
        reset            = rstv;
        bus.load_use     = lu;
        bus.branch_taken = bt;
        bus.mc_start     = ms;
        bus.mem_wait     = mw;
        x.nm   = nm;
        x.pc   = xpc;
        x.en   = xen;
        x.clr  = xclr;
        x.busy = xbusy;
        x.done = xdone;
        x.st   = exp_stall;
        q.push_back(x);
        if (!rstv)
            exp_stall = 16'd0;
        else if (!xpc && exp_stall != 16'hFFFF)
            exp_stall = exp_stall + 16'd1;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input string nm);
        step(nm, 1, 0, 0, 0, 0, 1, 4'b1111, 4'b0000, 0, 0);
    endtask

    task automatic mcw(input string nm);
        step(nm, 1, 0, 0, 1, 0, 0, 4'b1000, 4'b1000, 1, 0);
    endtask

    task automatic mcdone(input string nm);
        step(nm, 1, 0, 0, 1, 0, 1, 4'b1111, 4'b0000, 1, 1);
    endtask

    initial begin
        reset            = 1'b0;
        bus.load_use     = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mc_start     = 1'b0;
        bus.mem_wait     = 1'b0;
        exp_stall        = 16'd0;
        @(posedge clock);
        #1;

        // reset then idle
        step("rst0", 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1111, 0, 0);
        step("rst1", 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1111, 0, 0);
        for (int i = 0; i < 10; i++) idle("idle");

        // multi-cycle op, MC_LAT=4
        mcw("mc_c0"); mcw("mc_c1"); mcw("mc_c2"); mcdone("mc_c3");
        idle("mc_after");

        // precedence in RUN
        step("br_lu", 1, 1, 1, 0, 0, 1, 4'b1111, 4'b0011, 0, 0);
        step("br_lu_mw", 1, 1, 1, 0, 1, 0, 4'b0000, 4'b0000, 0, 0);
        step("lu", 1, 1, 0, 0, 0, 0, 4'b1110, 4'b0010, 0, 0);
        step("br", 1, 0, 1, 0, 0, 1, 4'b1111, 4'b0011, 0, 0);
        idle("prec_after");

        // mc_start held past mc_done starts a fresh op
        mcw("b2b_c0"); mcw("b2b_c1"); mcw("b2b_c2"); mcdone("b2b_c3");
        mcw("b2b_n0"); mcw("b2b_n1"); mcw("b2b_n2"); mcdone("b2b_n3");
        idle("b2b_after");

        // mem_wait at cnt==0 delays release
        mcw("mwz_c0"); mcw("mwz_c1"); mcw("mwz_c2");
        step("mwz_w0", 1, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 1, 0);
        step("mwz_w1", 1, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 1, 0);
        mcdone("mwz_done");
        idle("mwz_after");

        // mem_wait mid-count does not stretch the op; branch/load_use ignored
        mcw("mwm_c0");
        step("mwm_w", 1, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 1, 0);
        step("mwm_brlu", 1, 1, 1, 1, 0, 0, 4'b1000, 4'b1000, 1, 0);
        mcdone("mwm_done");
        idle("mwm_after");

        // mem_wait masks mc_start in RUN
        step("mw_ms", 1, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 0, 0);
        mcw("mw_ms_c0"); mcw("mw_ms_c1"); mcw("mw_ms_c2"); mcdone("mw_ms_c3");
        idle("mw_ms_after");

        // reset during MC_WAIT aborts the op
        mcw("abort_c0"); mcw("abort_c1");
        step("abort_rst", 0, 0, 0, 1, 0, 0, 4'b0000, 4'b1111, 0, 0);
        idle("abort_run");
        idle("abort_run2");

        // stall counter saturation
        for (int i = 0; i < 70000; i++)
            step("sat", 1, 1, 0, 0, 0, 0, 4'b1110, 4'b0010, 0, 0);
        idle("sat_final");
        idle("sat_hold");

        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter MC_LAT, default 4: multi-cycle EX unit latency in cycles; legal range 2..2^CNT_W+1.
REQ-002 Parameter CNT_W, default 3: width of the multi-cycle down-counter.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 load_use  in  1  ID instruction depends on load currently in EX.
REQ-006 branch_taken  in  1  EX resolved a taken branch this cycle.
REQ-007 mc_start  in  1  instruction in EX is multi-cycle; held high until that instruction leaves EX.
REQ-008 mem_wait  in  1  data memory not ready this cycle.
REQ-009 pc_en  out  1  PC register enable.
REQ-010 en  out  4  stage register enables: [0] IF/ID, [1] ID/EX, [2] EX/MEM, [3] MEM/WB.
REQ-011 clr  out  4  stage register synchronous clears (bubble insert), same bit order; clr overrides en at the stage register.
REQ-012 busy  out  1  high while a multi-cycle op holds EX.
REQ-013 mc_done  out  1  one-cycle pulse, multi-cycle result released to EX/MEM.
REQ-014 stall_cnt  out  16  count of cycles with pc_en=0.

Function
REQ-015 FSM states SHALL be RUN and MC_WAIT, plus CNT_W-bit counter cnt; outputs combinational from state, cnt and inputs.
REQ-016 RUN priority, highest first: mem_wait, mc_start, branch_taken, load_use, none.
REQ-017 RUN+mem_wait: pc_en=0, en=0000, clr=0000; state unchanged; mc_start ignored this cycle.
REQ-018 RUN+mc_start: pc_en=0, en=1000, clr=1000, busy=1; next state MC_WAIT, cnt<=MC_LAT-2.
REQ-019 RUN+branch_taken: pc_en=1, en=1111, clr=0011 (flush IF/ID, ID/EX).
REQ-020 RUN+load_use: pc_en=0, en=1110, clr=0010 (hold IF/ID and PC, bubble into ID/EX).
REQ-021 RUN, no request: pc_en=1, en=1111, clr=0000.
REQ-022 MC_WAIT, cnt!=0: busy=1, outputs as REQ-018 (or as REQ-017 if mem_wait); cnt decrements every cycle regardless of mem_wait.
REQ-023 MC_WAIT, cnt==0, mem_wait=0: mc_done=1, busy=1, pc_en=1, en=1111, clr=0000; next state RUN.
REQ-024 MC_WAIT, cnt==0, mem_wait=1: outputs as REQ-017, busy=1, mc_done=0; cnt held at 0; state unchanged.
REQ-025 branch_taken and load_use SHALL be ignored in MC_WAIT.
REQ-026 Total stall cycles for one multi-cycle op with mem_wait low SHALL be MC_LAT-1; mc_done in the MC_LAT-th cycle counted from the mc_start cycle.
REQ-027 mc_start still high in the cycle after mc_done is a new op (fresh REQ-018).
REQ-028 stall_cnt SHALL increment each cycle pc_en=0 with reset high, saturating at 16'hFFFF (no wrap).

Reset
REQ-029 reset low at an edge: state<=RUN, cnt<=0, stall_cnt<=0, regardless of state or inputs.
REQ-030 While reset low: pc_en=0, en=0000, clr=1111, busy=0, mc_done=0; stall_cnt not incremented.
REQ-031 Reset asserted during MC_WAIT SHALL abort the op; no mc_done is issued.

Verification
REQ-032 Idle: reset 0 for 2 cycles then 1, all inputs 0 -> pc_en=1, en=1111, clr=0000, stall_cnt=0 after 10 cycles.
REQ-033 Multi-cycle, MC_LAT=4: mc_start high 4 cycles -> busy 1 for cycles 0-3, pc_en=0 cycles 0-2, mc_done=1 only in cycle 3, stall_cnt=3.
REQ-034 Precedence: load_use=1, branch_taken=1 same cycle -> clr=0011, pc_en=1; add mem_wait=1 -> en=0000, clr=0000.
REQ-035 mem_wait=1 for 2 cycles starting at cnt==0 in MC_WAIT -> mc_done delayed 2 cycles, en=0000 during wait, then single mc_done pulse.
REQ-036 reset=0 during cnt=1 of MC_WAIT -> next cycle RUN, busy=0, no mc_done; stall_cnt=0.
REQ-037 load_use held 70000 cycles -> stall_cnt saturates at 16'hFFFF.
